// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//   Read-domain adapter between a first-word-fall-through dual-clock FIFO and
//   a valid/ready stream. A two-entry buffer (main + skid) sustains one word
//   per cycle. The pop strobe depends only on registered state, rempty and
//   flush, so m_ready never reaches rinc combinationally.
//
//   Optional feature: define FIFO_RD_STREAM_STATS_EN to add the transfer and
//   stall counters (xfer_cnt, stall_cnt).
//
// Ports
//   rclk      in   1      read-domain clock
//   rrst_n    in   1      asynchronous active-low reset
//   rempty    in   1      FIFO empty flag
//   rdata     in   DSIZE  FIFO fall-through read data
//   rinc      out  1      FIFO pop strobe
//   flush     in   1      synchronous discard of buffered words
//   m_valid   out  1      output word valid (registered)
//   m_ready   in   1      downstream accepts word
//   m_data    out  DSIZE  output word (main register)
//   m_level   out  2      words held: 0, 1 or 2
//   xfer_cnt  out  32     accepted words       (FIFO_RD_STREAM_STATS_EN only)
//   stall_cnt out  32     cycles valid & !ready (FIFO_RD_STREAM_STATS_EN only)
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
`ifdef FIFO_RD_STREAM_STATS_EN
    output logic [31:0]      xfer_cnt,
    output logic [31:0]      stall_cnt,
`endif
    output logic [1:0]       m_level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q;
    logic             m_valid_q;
    logic [DSIZE-1:0] main_q;
    logic [DSIZE-1:0] skid_q;
    logic             pop;
    logic             take;

    // Pop whenever there is room; room is judged from registered state only,
    // which keeps m_ready off the FIFO read path. Gated by reset so no pop is
    // signalled while the block is held in reset.
    assign pop  = rrst_n && !rempty && (state_q != TWO) && !flush;
    assign take = m_valid_q && m_ready;

    assign rinc    = pop;
    assign m_valid = m_valid_q;
    assign m_data  = main_q;
    assign m_level = state_q;

    // Main always holds the older word; skid is only occupied in TWO.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q   <= EMPTY;
            m_valid_q <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            // Buffered words are dropped; a take in this cycle is ignored.
            state_q   <= EMPTY;
            m_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (pop) begin
                        main_q    <= rdata;
                        state_q   <= ONE;
                        m_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (pop && take) begin
                        main_q <= rdata;
                    end else if (pop) begin
                        skid_q  <= rdata;
                        state_q <= TWO;
                    end else if (take) begin
                        state_q   <= EMPTY;
                        m_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (take) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q   <= EMPTY;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] xfer_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] xfer_cnt_d;
    logic [31:0] stall_cnt_d;

    // A take during flush discards the word, so it is not counted.
    always_comb begin
        xfer_cnt_d  = xfer_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (take && !flush) begin
            xfer_cnt_d = xfer_cnt_q + 32'd1;
        end
        if (m_valid_q && !m_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign xfer_cnt  = xfer_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    logic       rclk;
    logic       rrst_n;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       flush;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] m_level;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] xfer_cnt;
    logic [31:0] stall_cnt;
`endif

    fifo_rd_stream #(.DSIZE(8)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
`ifdef FIFO_RD_STREAM_STATS_EN
        .xfer_cnt (xfer_cnt),
        .stall_cnt(stall_cnt),
`endif
        .m_level  (m_level)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        bit         push;
        logic [7:0] pdata;
        bit         rdy;
        bit         fl;
        bit         exp_rinc;
        bit         exp_valid;
        logic [1:0] exp_level;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] fifo[$];   // words still inside the upstream FIFO
    logic [7:0] sb[$];     // scoreboard: words popped but not yet taken
    int         pass_cnt;
    int         total_cnt;
    bit         prev_stall;
    logic [7:0] prev_data;
    int         takes;
    int         xfer_m;
    int         stall_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Called just after a falling edge: check settled state, then drive inputs.
    task automatic drive(input bit rdy, input bit fl, input bit gate);
        chk("level_vs_model", {30'd0, m_level}, sb.size());
        chk("valid_vs_model", {31'd0, m_valid}, {31'd0, sb.size() != 0});
        if (prev_stall) begin
            chk("stall_valid_held", {31'd0, m_valid}, 32'd1);
            chk("stall_data_held", {24'd0, m_data}, {24'd0, prev_data});
        end
        m_ready = rdy;
        flush   = fl;
        rempty  = gate || (fifo.size() == 0);
        rdata   = (fifo.size() != 0) ? fifo[0] : 8'h00;
        #1;
        chk("rinc_rule", {31'd0, rinc},
            {31'd0, (!rempty && sb.size() < 2 && !flush)});
        if (rempty && rinc) chk("pop_while_empty", 32'd1, 32'd0);
    endtask

    // Account for what the coming rising edge does, then advance one cycle.
    task automatic finish_cycle();
        bit take;
        take = m_valid && m_ready && !flush;
        if (m_valid && !m_ready) stall_m++;
        if (take) begin
            xfer_m++;
            takes++;
            if (sb.size() == 0) chk("take_with_model_empty", 32'd1, 32'd0);
            else chk("data_order", {24'd0, m_data}, {24'd0, sb.pop_front()});
        end
        prev_stall = m_valid && !m_ready && !flush;
        prev_data  = m_data;
        if (flush) sb.delete();
        if (rinc) begin
            if (fifo.size() == 0) chk("pop_of_empty_fifo", 32'd1, 32'd0);
            else sb.push_back(fifo.pop_front());
        end
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic cyc(input bit rdy, input bit fl, input bit gate);
        drive(rdy, fl, gate);
        finish_cycle();
    endtask

    function automatic void P(input logic [7:0] d);
        vec_t v;
        v = '{push: 1'b1, pdata: d, rdy: 1'b0, fl: 1'b0, exp_rinc: 1'b0,
              exp_valid: 1'b0, exp_level: 2'd0, exp_data: 8'h00};
        vecs.push_back(v);
    endfunction

    function automatic void V(input bit rdy, input bit fl, input bit er,
                              input bit ev, input logic [1:0] el, input logic [7:0] ed);
        vec_t v;
        v = '{push: 1'b0, pdata: 8'h00, rdy: rdy, fl: fl, exp_rinc: er,
              exp_valid: ev, exp_level: el, exp_data: ed};
        vecs.push_back(v);
    endfunction

    task automatic model_reset();
        sb.delete();
        prev_stall = 1'b0;
        xfer_m     = 0;
        stall_m    = 0;
    endtask

    initial begin
        int n_pushed;
        int start_takes;
        int budget;
        pass_cnt  = 0;
        total_cnt = 0;
        takes     = 0;
        model_reset();

        // Reset: rinc must stay low even with rempty low.
        rrst_n  = 1'b0;
        rempty  = 1'b0;
        rdata   = 8'h5A;
        flush   = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("reset_rinc", {31'd0, rinc}, 32'd0);
        chk("reset_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_level", {30'd0, m_level}, 32'd0);
        chk("reset_data", {24'd0, m_data}, 32'd0);
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;

        // Table: idle, streaming, backpressure, flush.
        V(1, 0, 0, 0, 2'd0, 8'h00);
        V(1, 0, 0, 0, 2'd0, 8'h00);
        V(1, 0, 0, 0, 2'd0, 8'h00);
        P(8'h11); P(8'h22); P(8'h33);
        V(1, 0, 1, 0, 2'd0, 8'h00);
        V(1, 0, 1, 1, 2'd1, 8'h11);
        V(1, 0, 1, 1, 2'd1, 8'h22);
        V(1, 0, 0, 1, 2'd1, 8'h33);
        V(1, 0, 0, 0, 2'd0, 8'h00);
        P(8'hA0); P(8'hA1); P(8'hA2); P(8'hA3);
        V(0, 0, 1, 0, 2'd0, 8'h00);
        V(0, 0, 1, 1, 2'd1, 8'hA0);
        V(0, 0, 0, 1, 2'd2, 8'hA0);
        V(0, 0, 0, 1, 2'd2, 8'hA0);
        V(1, 0, 0, 1, 2'd2, 8'hA0);
        V(1, 0, 1, 1, 2'd1, 8'hA1);
        V(1, 0, 1, 1, 2'd1, 8'hA2);
        V(1, 0, 0, 1, 2'd1, 8'hA3);
        V(1, 0, 0, 0, 2'd0, 8'h00);
        P(8'hB0); P(8'hB1); P(8'hB2); P(8'hB3); P(8'hB4);
        V(0, 0, 1, 0, 2'd0, 8'h00);
        V(0, 0, 1, 1, 2'd1, 8'hB0);
        V(0, 0, 0, 1, 2'd2, 8'hB0);
        V(0, 1, 0, 1, 2'd2, 8'hB0);
        V(1, 0, 1, 0, 2'd0, 8'h00);
        V(1, 0, 1, 1, 2'd1, 8'hB2);
        V(1, 0, 1, 1, 2'd1, 8'hB3);
        V(1, 0, 0, 1, 2'd1, 8'hB4);
        V(1, 0, 0, 0, 2'd0, 8'h00);
        P(8'hC0); P(8'hC1);
        V(1, 0, 1, 0, 2'd0, 8'h00);
        V(1, 1, 0, 1, 2'd1, 8'hC0);
        V(1, 0, 1, 0, 2'd0, 8'h00);
        V(1, 0, 0, 1, 2'd1, 8'hC1);
        V(1, 0, 0, 0, 2'd0, 8'h00);

        foreach (vecs[i]) begin
            if (vecs[i].push) begin
                fifo.push_back(vecs[i].pdata);
            end else begin
                chk($sformatf("vec%0d_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].exp_valid});
                chk($sformatf("vec%0d_level", i), {30'd0, m_level}, {30'd0, vecs[i].exp_level});
                if (vecs[i].exp_valid)
                    chk($sformatf("vec%0d_data", i), {24'd0, m_data}, {24'd0, vecs[i].exp_data});
                drive(vecs[i].rdy, vecs[i].fl, 1'b0);
                chk($sformatf("vec%0d_rinc", i), {31'd0, rinc}, {31'd0, vecs[i].exp_rinc});
                finish_cycle();
            end
        end

        // rempty toggling every cycle.
        for (int k = 0; k < 8; k++) fifo.push_back(8'h60 + 8'(k));
        for (int c = 0; c < 40; c++) cyc(1'b1, 1'b0, c[0]);
        chk("toggle_drained", fifo.size() + sb.size(), 32'd0);

        // 256 words, random producer gaps and random m_ready.
        n_pushed    = 0;
        start_takes = takes;
        budget      = 0;
        while ((takes - start_takes) < 256 && budget < 5000) begin
            if (n_pushed < 256 && ($urandom % 2) == 0) begin
                fifo.push_back(8'($urandom));
                n_pushed++;
            end
            cyc(($urandom % 3) != 0, 1'b0, ($urandom % 4) == 0);
            budget++;
        end
        chk("random_words_delivered", takes - start_takes, 32'd256);

`ifdef FIFO_RD_STREAM_STATS_EN
        // Fresh counters: 10 takes, 4 stall cycles.
        rrst_n = 1'b0;
        #1;
        model_reset();
        fifo.delete();
        @(negedge rclk);
        rrst_n = 1'b1;
        for (int k = 0; k < 10; k++) fifo.push_back(8'hD0 + 8'(k));
        for (int c = 0; c < 5; c++) cyc(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 15; c++) cyc(1'b1, 1'b0, 1'b0);
        chk("stats_xfer", xfer_cnt, xfer_m);
        chk("stats_stall", stall_cnt, stall_m);
        chk("stats_flush_no_clear_x", xfer_cnt, xfer_m);
`endif

        // Reset asserted mid-transfer.
        for (int k = 0; k < 6; k++) fifo.push_back(8'hE0 + 8'(k));
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("midreset_valid", {31'd0, m_valid}, 32'd0);
        chk("midreset_level", {30'd0, m_level}, 32'd0);
        chk("midreset_data", {24'd0, m_data}, 32'd0);
        chk("midreset_rinc", {31'd0, rinc}, 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
        chk("midreset_xfer", xfer_cnt, 32'd0);
        chk("midreset_stall", stall_cnt, 32'd0);
`endif
        model_reset();
        @(negedge rclk);
        rrst_n = 1'b1;
        for (int c = 0; c < 12; c++) cyc(1'b1, 1'b0, 1'b0);
        chk("post_reset_drained", fifo.size() + sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
